// File: rtl/fpu_issue_ctrl.sv
// rtl/fpu_issue_ctrl.sv - in-order command FIFO and single-issue sequencer for the fpu datapath
module fpu_issue_ctrl #(
  parameter int DEPTH = 4,
  parameter int LAT   = 1,
  parameter int TW    = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [31:0]              cmd_a,
  input  logic [31:0]              cmd_b,
  input  logic [1:0]               cmd_op,
  input  logic [TW-1:0]            cmd_tag,
  output logic [31:0]              fpu_a,
  output logic [31:0]              fpu_b,
  output logic [1:0]               fpu_op,
  input  logic [31:0]              fpu_result,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [31:0]              rsp_data,
  output logic [1:0]               rsp_op,
  output logic [TW-1:0]            rsp_tag,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [3:0] WAIT_INIT = 4'(LAT - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t        state, state_nxt;
  logic [31:0]   fifo_a   [DEPTH];
  logic [31:0]   fifo_b   [DEPTH];
  logic [1:0]    fifo_op  [DEPTH];
  logic [TW-1:0] fifo_tag [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [3:0]    wait_cnt;
  logic          push, pop, capture;

  assign cmd_ready = !rst && (count != FULL);
  assign push      = cmd_valid && cmd_ready;
  assign busy      = (state != IDLE);

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) begin
          pop       = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (wait_cnt == 4'd0) begin
          capture   = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        // the next command issues in the handshake cycle so throughput is LAT+1
        if (rsp_ready) begin
          if (count != '0) begin
            pop       = 1'b1;
            state_nxt = WAIT;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_a[wr_ptr]   <= cmd_a;
      fifo_b[wr_ptr]   <= cmd_b;
      fifo_op[wr_ptr]  <= cmd_op;
      fifo_tag[wr_ptr] <= cmd_tag;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      wait_cnt  <= 4'd0;
      fpu_a     <= 32'd0;
      fpu_b     <= 32'd0;
      fpu_op    <= 2'd0;
      rsp_valid <= 1'b0;
      rsp_data  <= 32'd0;
      rsp_op    <= 2'd0;
      rsp_tag   <= '0;
    end else begin
      state <= state_nxt;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr   <= rd_ptr + 1'b1;
        fpu_a    <= fifo_a[rd_ptr];
        fpu_b    <= fifo_b[rd_ptr];
        fpu_op   <= fifo_op[rd_ptr];
        rsp_op   <= fifo_op[rd_ptr];
        rsp_tag  <= fifo_tag[rd_ptr];
        wait_cnt <= WAIT_INIT;
      end else if (state == WAIT && wait_cnt != 4'd0) begin
        wait_cnt <= wait_cnt - 1'b1;
      end
      if (capture) begin
        rsp_data  <= fpu_result;
        rsp_valid <= 1'b1;
      end else if (state == RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: doc/fpu_issue_ctrl.md
Name: fpu_issue_ctrl

Overview:
- Initiator/sequencer for the team's fpu datapath block; the fpu is the responder.
- Accepts operation commands (a, b, op, tag) over a valid/ready interface and buffers them in a small in-order FIFO.
- Drives registered operands and opcode into the fpu, waits a configurable settle latency, then captures the fpu result.
- Returns result, opcode and tag over a valid/ready response interface, strictly in command order, one operation in flight.

Parameters:
- DEPTH, 4, command FIFO depth in entries; power of 2, minimum 2.
- LAT, 1, cycles from fpu operand registers updating to result capture; legal range 1..15.
- TW, 4, tag width in bits.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  FIFO can accept a command this cycle.
- cmd_a  input  32  operand a.
- cmd_b  input  32  operand b.
- cmd_op  input  2  00 add, 01 sub, 10 mul, 11 div.
- cmd_tag  input  TW  opaque tag returned with the result.
- fpu_a  output  32  registered operand a to the fpu.
- fpu_b  output  32  registered operand b to the fpu.
- fpu_op  output  2  registered opcode to the fpu.
- fpu_result  input  32  fpu result.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer accepts the response.
- rsp_data  output  32  captured fpu result.
- rsp_op  output  2  opcode of this response.
- rsp_tag  output  TW  tag of this response.
- busy  output  1  1 in any state other than IDLE.
- count  output  $clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (asynchronous, active-high):
  - fpu_a, fpu_b, fpu_op, rsp_data, rsp_op and rsp_tag all go to 0.
  - rsp_valid, busy and count go to 0.
  - FIFO pointers are cleared and the FSM goes to IDLE.
  - cmd_ready is 0 while rst is high.
  - Any in-flight operation and all queued commands are discarded; no response is produced for them.
- cmd_ready = !rst && (count != DEPTH). There is no full-FIFO look-ahead: when full, a same-cycle pop does not allow a push.
- Push occurs on cmd_valid && cmd_ready.
- Pop is internal (ISSUE). When push and pop occur in the same cycle, count is unchanged.
- Pointers wrap modulo DEPTH.
- FSM:
  - IDLE: if count != 0, pop the head. In that cycle fpu_a, fpu_b, fpu_op, rsp_op and rsp_tag are loaded from the head. Load the wait counter with LAT-1 and go to WAIT.
  - WAIT: decrement the counter each cycle. In the cycle the counter is 0, register fpu_result into rsp_data, set rsp_valid and go to RESP.
  - RESP: hold rsp_valid and all rsp_* fields stable until rsp_ready.
    - On handshake with count != 0: pop and load the next command in the same cycle, clear rsp_valid, go to WAIT.
    - On handshake with count == 0: clear rsp_valid, go to IDLE.
- Latency:
  - Command pushed into an empty FIFO while IDLE at edge E0 is popped at E1.
  - Result captured at E1+LAT; rsp_valid is visible after edge E1+LAT.
  - With LAT=1, rsp_valid is high in the cycle after E2.
- Throughput with rsp_ready held at 1: one response every LAT+1 cycles.
- fpu_a, fpu_b and fpu_op hold their last issued values while IDLE, so the fpu inputs stay quiet.
- No arithmetic is performed locally; rsp_data is exactly fpu_result at the capture edge, with no special handling of divide-by-zero.
- Ordering: responses come out in push order. Tags are not interpreted.
- rsp_ready asserted while rsp_valid is 0 is ignored.

Test Plan:
- Single add, LAT=1, paired with the fpu: push a=5, b=3, op=00, tag=2 at E0 with rsp_ready=1 -> rsp_valid after E2 with rsp_data=8, rsp_op=00, rsp_tag=2; busy returns to 0 one cycle after the handshake.
- Back-to-back ordering: push (9,4,01,t1), (6,7,10,t2), (20,5,11,t3) -> responses 5/t1, 42/t2, 4/t3 in order, spaced LAT+1 cycles apart.
- Backpressure and full: rsp_ready=0, push DEPTH+2 commands -> one command is in flight and count reaches DEPTH. cmd_ready=0 when full; the held rsp fields stay stable. Release rsp_ready -> all DEPTH+1 accepted commands are returned in order and the rest are never accepted.
- LAT=3 timing: push (1,1,00) at E0 -> fpu_a=1 after E1, capture at E4, rsp_data=2; check that no response appears earlier.
- Simultaneous push and pop at count=2 -> count stays 2; pointer wrap exercised across more than 2*DEPTH commands with correct data.
- Reset mid-WAIT with 2 commands queued -> immediate reset of all outputs and count, no response emitted; a new command after reset is processed normally.
